// File: rtl/key_flag_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
`timescale 1ns/1ps
package key_flag_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  // Raw button level that means "pressed" (the pin is active-low).
  localparam logic KEY_PRESSED = 1'b0;

endpackage

// File: rtl/key_flag_debounce_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset and a
// configurable reset value.
`timescale 1ns/1ps
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= RESET_VALUE;
      q        <= RESET_VALUE;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/key_flag_debounce.sv
// Push-button debouncer: a level change is accepted only after the
// synchronized input has held the new level for MASK_TIME cycles.
`timescale 1ns/1ps
module key_flag_debounce
  import key_flag_pkg::*;
#(
  parameter int MASK_TIME = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_out
);

  if (MASK_TIME < 1 || MASK_TIME > (1 << 20)) begin : g_bad_mask_time
    $error("key_flag_debounce: MASK_TIME must be in 1..2^20");
  end

  localparam int                 CNT_W    = $clog2(MASK_TIME + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MASK_TIME - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MASK_TIME);

  logic             key_s;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;

  sync_2ff #(
    .WIDTH      (1),
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst_n),
    .d  (key_n),
    .q  (key_s)
  );

  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

  // ">=" rather than "==" lets MASK_TIME=1 leave a filter state after one
  // cycle even though the count enters at 1.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      key_out   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (key_s == KEY_PRESSED) begin
            state_reg <= PRESS_FILT;
            cnt_reg   <= CNT_ONE;
          end
        end
        PRESS_FILT: begin
          if (key_s != KEY_PRESSED) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg >= CNT_LAST) begin
            state_reg <= DOWN;
            cnt_reg   <= '0;
            key_out   <= 1'b1;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        DOWN: begin
          if (key_s != KEY_PRESSED) begin
            state_reg <= REL_FILT;
            cnt_reg   <= CNT_ONE;
          end
        end
        REL_FILT: begin
          if (key_s == KEY_PRESSED) begin
            state_reg <= DOWN;
            cnt_reg   <= '0;
          end else if (cnt_reg >= CNT_LAST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            key_out   <= 1'b0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          key_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_flag_debounce.sv
// Randomized bench for key_flag_debounce against a run-length model of the
// accepted button level.
`timescale 1ns/1ps
module tb_key_flag_debounce;

  localparam int MASK_TIME = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic key_n = 1'b1;
  logic key_out;

  int n_pass   = 0;
  int n_total  = 0;
  int edge_cnt = 0;

  key_flag_debounce #(.MASK_TIME(MASK_TIME)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .key_out(key_out)
  );

  always #10 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Model: key_s is key_n delayed by two samples; the accepted level flips
  // once MASK_TIME consecutive samples disagree with it.
  logic [1:0] m_hist;
  int         m_run;
  logic       m_out;

  always @(posedge clk or posedge rst_n) begin : model
    int   run_n;
    logic out_n;
    logic pressed_seen;
    if (rst_n) begin
      m_hist <= 2'b11;
      m_run  <= 0;
      m_out  <= 1'b0;
    end else begin
      pressed_seen = ~m_hist[1];
      out_n        = m_out;
      run_n        = (pressed_seen != m_out) ? m_run + 1 : 0;
      if (run_n >= MASK_TIME) begin
        out_n = pressed_seen;
        run_n = 0;
      end
      m_run  <= run_n;
      m_out  <= out_n;
      m_hist <= {m_hist[0], key_n};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) check("cycle key_out vs model", {31'd0, key_out}, {31'd0, m_out});

  task automatic hold(input logic lvl, input int ns);
    key_n = lvl;
    #(ns);
  endtask

  // Place subsequent key_n edges away from clock edges.
  task automatic align();
    @(posedge clk);
    #3;
  endtask

  // Wait (bounded) for key_out to reach lvl; require it 7 edges after start,
  // the first sampling edge being start+1.
  task automatic measure(input logic lvl, input int start, input string name);
    int k = 0;
    while (key_out !== lvl && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, " level"}, {31'd0, key_out}, {31'd0, lvl});
    check({name, " edges"}, edge_cnt - start, 7);
    $display("%s: key_out=%0d after %0d edges", name, key_out, edge_cnt - start);
  endtask

  initial begin
    int s;
    int dur;
    // Reset hold with button released
    #200;
    rst_n = 1'b0;
    align();
    hold(1'b1, 200);
    check("idle after reset", {31'd0, key_out}, 32'd0);
    $display("reset hold: key_out=%0d", key_out);

    // Bounced press: longest low run is 4 samples
    hold(1'b0, 10);
    hold(1'b1, 20);
    hold(1'b0, 80);
    hold(1'b1, 200);
    check("bounced press rejected", {31'd0, key_out}, 32'd0);
    $display("bounced press: key_out=%0d", key_out);

    // Valid press
    align();
    key_n = 1'b0;
    s = edge_cnt;
    measure(1'b1, s, "valid press");
    align();
    hold(1'b0, 200);
    check("press held", {31'd0, key_out}, 32'd1);

    // Bounced release while pressed
    hold(1'b1, 10);
    hold(1'b0, 20);
    hold(1'b1, 80);
    hold(1'b0, 200);
    check("bounced release rejected", {31'd0, key_out}, 32'd1);
    $display("bounced release: key_out=%0d", key_out);

    // Valid release
    align();
    key_n = 1'b1;
    s = edge_cnt;
    measure(1'b0, s, "valid release");
    align();
    hold(1'b1, 200);
    check("release held", {31'd0, key_out}, 32'd0);

    // Reset in PRESS_FILT with count 3, then re-press after release
    align();
    key_n = 1'b0;
    repeat (5) @(posedge clk);
    #5 rst_n = 1'b1;
    #1 check("reset mid-filter", {31'd0, key_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    s = edge_cnt;
    measure(1'b1, s, "press after reset");

    // Reset while DOWN clears key_out immediately
    #5 rst_n = 1'b1;
    #1 check("reset while down", {31'd0, key_out}, 32'd0);
    $display("reset while down: key_out=%0d", key_out);
    @(negedge clk);
    rst_n = 1'b0;
    align();
    hold(1'b1, 200);

    // Random bouncing; the per-cycle compare does the checking
    for (int i = 0; i < 250; i++) begin
      dur = ($urandom_range(0, 4) == 0) ? 200 : 10 * $urandom_range(1, 16);
      hold(1'($urandom_range(0, 1)), dur);
    end
    hold(1'b1, 200);
    check("final released", {31'd0, key_out}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
